// File: rtl/shared_mac_unit.sv
// Resource-shared arithmetic responder.
// Altitude op : a*K1 + b*K2 (two multiply passes: MUL1 then MUL2)
// Battery op  : a*b + c     (one multiply-add pass in MUL1)
// One signed multiplier and one adder are time-shared between the ops.
// Requests and results each use a valid/ready handshake.
module shared_mac_unit #(
  parameter int                        DATA_W = 8,
  parameter logic signed [DATA_W-1:0]  ALT_K1 = 8'sd3,
  parameter logic signed [DATA_W-1:0]  ALT_K2 = 8'sd5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [DATA_W-1:0]     a_in,
  input  logic [DATA_W-1:0]     b_in,
  input  logic [DATA_W-1:0]     c_in,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*DATA_W-1:0]   rsp_result,
  output logic                  rsp_op,
  output logic                  busy,
  output logic [15:0]           ops_done
);

  localparam int RES_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL1 = 2'd1,
    MUL2 = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;

  logic                op_r;
  logic [DATA_W-1:0]   a_r;
  logic [DATA_W-1:0]   b_r;
  logic [DATA_W-1:0]   c_r;
  logic [RES_W-1:0]    acc_r;

  logic [RES_W-1:0]    rsp_result_r;
  logic                rsp_op_r;
  logic                rsp_valid_r;
  logic [15:0]         ops_done_r;

  logic                accept_s;
  logic                load_rsp_s;
  logic                rsp_fire_s;
  logic [DATA_W-1:0]   mul_a_s;
  logic [DATA_W-1:0]   mul_b_s;
  logic [RES_W-1:0]    mul_a_ext_s;
  logic [RES_W-1:0]    mul_b_ext_s;
  logic [RES_W-1:0]    product_s;
  logic [RES_W-1:0]    addend_s;
  logic [RES_W-1:0]    sum_s;

  // A request is accepted only from IDLE; there is no queueing while busy.
  assign accept_s   = req_valid && (state_r == IDLE);
  assign rsp_fire_s = (state_r == RESP) && rsp_ready;
  // Result registers load on the edge that enters RESP from a compute state.
  assign load_rsp_s = (state_nxt_s == RESP) && (state_r != RESP);

  // Next-state logic: altitude needs a second multiply pass, battery does not.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = MUL1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL1: begin
        if (op_r) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = MUL2;
        end
      end
      MUL2: begin
        state_nxt_s = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Operand and addend muxes steering the single shared multiplier and adder.
  always_comb begin
    mul_a_s  = a_r;
    mul_b_s  = ALT_K1;
    addend_s = {RES_W{1'b0}};
    case (state_r)
      MUL1: begin
        if (op_r) begin
          mul_a_s  = a_r;
          mul_b_s  = b_r;
          addend_s = {{DATA_W{c_r[DATA_W-1]}}, c_r};
        end else begin
          mul_a_s  = a_r;
          mul_b_s  = ALT_K1;
          addend_s = {RES_W{1'b0}};
        end
      end
      MUL2: begin
        mul_a_s  = b_r;
        mul_b_s  = ALT_K2;
        addend_s = acc_r;
      end
      default: begin
        mul_a_s  = a_r;
        mul_b_s  = ALT_K1;
        addend_s = {RES_W{1'b0}};
      end
    endcase
  end

  // Sign-extend to full width so the low RES_W bits equal the signed product.
  assign mul_a_ext_s = {{DATA_W{mul_a_s[DATA_W-1]}}, mul_a_s};
  assign mul_b_ext_s = {{DATA_W{mul_b_s[DATA_W-1]}}, mul_b_s};
  assign product_s   = mul_a_ext_s * mul_b_ext_s;
  assign sum_s       = product_s + addend_s;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture, accumulator, result registers and completion counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_r         <= 1'b0;
      a_r          <= {DATA_W{1'b0}};
      b_r          <= {DATA_W{1'b0}};
      c_r          <= {DATA_W{1'b0}};
      acc_r        <= {RES_W{1'b0}};
      rsp_result_r <= {RES_W{1'b0}};
      rsp_op_r     <= 1'b0;
      rsp_valid_r  <= 1'b0;
      ops_done_r   <= 16'd0;
    end else begin
      if (accept_s) begin
        op_r <= req_op;
        a_r  <= a_in;
        b_r  <= b_in;
        c_r  <= c_in;
      end
      if ((state_r == MUL1) || (state_r == MUL2)) begin
        acc_r <= sum_s;
      end
      if (load_rsp_s) begin
        rsp_result_r <= sum_s;
        rsp_op_r     <= op_r;
        rsp_valid_r  <= 1'b1;
      end else if (rsp_fire_s) begin
        rsp_valid_r <= 1'b0;
        ops_done_r  <= ops_done_r + 16'd1;
      end
    end
  end

  assign req_ready  = (state_r == IDLE);
  assign busy       = (state_r != IDLE);
  assign rsp_valid  = rsp_valid_r;
  assign rsp_result = rsp_result_r;
  assign rsp_op     = rsp_op_r;
  assign ops_done   = ops_done_r;

endmodule

// File: tb/tb_shared_mac_unit.sv
// Self-checking bench for shared_mac_unit: directed, randomized, backpressure,
// mid-operation reset and back-to-back scenarios against an arithmetic model.
module tb_shared_mac_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic [7:0]  c_in;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_op;
  logic        busy;
  logic [15:0] ops_done;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_ops   = 0;

  shared_mac_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_op(rsp_op),
    .busy(busy), .ops_done(ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, truncated to the 16-bit result.
  function automatic logic [15:0] model(input logic op, input logic signed [7:0] a,
                                        input logic signed [7:0] b, input logic signed [7:0] c);
    int r;
    if (op) r = int'(a) * int'(b) + int'(c);
    else    r = int'(a) * 3 + int'(b) * 5;
    return r[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, scramble inputs after the accept edge, wait for rsp_valid.
  // lat counts edges from (and including) the accept edge until rsp_valid is seen.
  task automatic issue(input logic op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, output int lat);
    req_op = op; a_in = a; b_in = b; c_in = c; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    a_in = 8'($urandom); b_in = 8'($urandom); c_in = 8'($urandom); req_op = 1'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b want 1", req_ready); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_result !== 16'h0000) $display("FAIL rst_rsp_result: got %h want 0000", rsp_result); else pass_cnt++;
    total_cnt++; if (rsp_op !== 1'b0) $display("FAIL rst_rsp_op: got %b want 0", rsp_op); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (ops_done !== 16'd0) $display("FAIL rst_ops_done: got %0d want 0", ops_done); else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  // Directed cases including operand extremes; rsp_ready held high.
  task automatic test_directed();
    logic        ops[5]   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0]  as[5]    = '{8'd2, 8'hFC, 8'h80, 8'h80, 8'h7F};
    logic [7:0]  bs[5]    = '{8'd3, 8'd2,  8'h80, 8'h80, 8'h80};
    logic [7:0]  cs[5]    = '{8'd0, 8'd5,  8'd0,  8'h7F, 8'h80};
    logic [15:0] want[5]  = '{16'd21, 16'hFFFD, 16'hFC00, 16'd16511, 16'hC000};
    int lat;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], as[i], bs[i], cs[i], lat);
      total_cnt++; if (lat !== (ops[i] ? 2 : 3)) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, ops[i] ? 2 : 3); else pass_cnt++;
      total_cnt++; if (rsp_result !== want[i]) $display("FAIL dir%0d_result: got %h want %h", i, rsp_result, want[i]); else pass_cnt++;
      total_cnt++; if (rsp_op !== ops[i]) $display("FAIL dir%0d_op: got %b want %b", i, rsp_op, ops[i]); else pass_cnt++;
      tick();
      exp_ops++;
      total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL dir%0d_valid_pulse: got %b want 0", i, rsp_valid); else pass_cnt++;
      total_cnt++; if (ops_done !== 16'(exp_ops)) $display("FAIL dir%0d_ops_done: got %0d want %0d", i, ops_done, exp_ops); else pass_cnt++;
    end
  endtask

  // Random operands and ops with random response stalls.
  task automatic test_random();
    logic op; logic [7:0] a, b, c; logic [15:0] exp; int lat; int stall;
    for (int i = 0; i < 16; i++) begin
      op = 1'($urandom); a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      exp = model(op, a, b, c);
      stall = $urandom_range(0, 3);
      rsp_ready = 1'b0;
      issue(op, a, b, c, lat);
      total_cnt++; if (rsp_result !== exp || rsp_op !== op) $display("FAIL rnd%0d_result: got %h/%b want %h/%b", i, rsp_result, rsp_op, exp, op); else pass_cnt++;
      for (int s = 0; s < stall; s++) begin
        tick();
        total_cnt++; if (rsp_valid !== 1'b1 || rsp_result !== exp) $display("FAIL rnd%0d_hold: got %b/%h want 1/%h", i, rsp_valid, rsp_result, exp); else pass_cnt++;
      end
      rsp_ready = 1'b1;
      tick();
      exp_ops++;
      total_cnt++; if (ops_done !== 16'(exp_ops)) $display("FAIL rnd%0d_ops_done: got %0d want %0d", i, ops_done, exp_ops); else pass_cnt++;
    end
  endtask

  // Stalled battery response while a second request waits at the input.
  task automatic test_backpressure();
    int lat; int n;
    rsp_ready = 1'b0;
    issue(1'b1, 8'd5, 8'd6, 8'd7, lat);
    req_op = 1'b0; a_in = 8'd1; b_in = 8'd1; c_in = 8'd9; req_valid = 1'b1;
    for (int s = 0; s < 5; s++) begin
      tick();
      total_cnt++; if (rsp_valid !== 1'b1 || rsp_result !== 16'd37 || req_ready !== 1'b0 || busy !== 1'b1)
        $display("FAIL bp_hold%0d: got v=%b r=%h rdy=%b busy=%b want v=1 r=0025 rdy=0 busy=1", s, rsp_valid, rsp_result, req_ready, busy);
      else pass_cnt++;
    end
    rsp_ready = 1'b1;
    tick();
    exp_ops++;
    total_cnt++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL bp_release: got rdy=%b v=%b want rdy=1 v=0", req_ready, rsp_valid); else pass_cnt++;
    tick();
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    total_cnt++; if (rsp_result !== 16'd8 || rsp_op !== 1'b0) $display("FAIL bp_second: got %h/%b want 0008/0", rsp_result, rsp_op); else pass_cnt++;
    tick();
    exp_ops++;
    total_cnt++; if (ops_done !== 16'(exp_ops)) $display("FAIL bp_ops_done: got %0d want %0d", ops_done, exp_ops); else pass_cnt++;
  endtask

  // Reset asserted in MUL2 of an altitude op drops it without a response.
  task automatic test_reset_midop();
    int lat;
    rsp_ready = 1'b1;
    req_op = 1'b0; a_in = 8'd10; b_in = 8'd10; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    #2 reset = 1'b0;
    #1;
    total_cnt++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || ops_done !== 16'd0)
      $display("FAIL midrst_state: got v=%b busy=%b ops=%0d want 0/0/0", rsp_valid, busy, ops_done);
    else pass_cnt++;
    tick(); tick();
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL midrst_no_rsp: got %b want 0", rsp_valid); else pass_cnt++;
    reset = 1'b1;
    exp_ops = 0;
    tick();
    issue(1'b1, 8'd3, 8'd3, 8'd0, lat);
    total_cnt++; if (rsp_result !== 16'd9) $display("FAIL midrst_after: got %0d want 9", rsp_result); else pass_cnt++;
    tick();
    exp_ops++;
    total_cnt++; if (ops_done !== 16'(exp_ops)) $display("FAIL midrst_ops_done: got %0d want %0d", ops_done, exp_ops); else pass_cnt++;
  endtask

  // Alternating altitude/battery requests held valid with rsp_ready tied high.
  task automatic test_back_to_back();
    logic [15:0] exp_q[$];
    logic        op_q[$];
    int sent = 0, got = 0, last_acc = -1, cyc = 0;
    logic last_op = 1'b0;
    logic acc_now, rsp_now;
    rsp_ready = 1'b1;
    req_op = 1'b0; a_in = 8'($urandom); b_in = 8'($urandom); c_in = 8'($urandom);
    req_valid = 1'b1;
    while (got < 8 && cyc < 200) begin
      acc_now = req_valid && req_ready;
      rsp_now = rsp_valid;
      if (rsp_now) begin
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL b2b_spurious: got %h want none", rsp_result);
        else if (rsp_result !== exp_q[0] || rsp_op !== op_q[0]) $display("FAIL b2b_result%0d: got %h/%b want %h/%b", got, rsp_result, rsp_op, exp_q[0], op_q[0]);
        else pass_cnt++;
        if (exp_q.size() != 0) begin void'(exp_q.pop_front()); void'(op_q.pop_front()); end
        got++;
        exp_ops++;
      end
      if (acc_now) begin
        exp_q.push_back(model(req_op, a_in, b_in, c_in));
        op_q.push_back(req_op);
        if (last_acc >= 0) begin
          total_cnt++; if (cyc - last_acc !== (last_op ? 3 : 4)) $display("FAIL b2b_spacing%0d: got %0d want %0d", sent, cyc - last_acc, last_op ? 3 : 4); else pass_cnt++;
        end
        last_acc = cyc;
        last_op = req_op;
      end
      tick();
      cyc++;
      if (acc_now) begin
        sent++;
        req_op = ~req_op; a_in = 8'($urandom); b_in = 8'($urandom); c_in = 8'($urandom);
        if (sent == 8) req_valid = 1'b0;
      end
    end
    total_cnt++; if (got !== 8) $display("FAIL b2b_count: got %0d want 8", got); else pass_cnt++;
    total_cnt++; if (ops_done !== 16'(exp_ops)) $display("FAIL b2b_ops_done: got %0d want %0d", ops_done, exp_ops); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_op = 1'b0;
    a_in = 8'd0; b_in = 8'd0; c_in = 8'd0; rsp_ready = 1'b0;
    #12;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
